// File: rtl/hssi_tc_mailbox_bridge.sv
// Host mailbox (CMD/ADDRESS/RDDATA/WRDATA) that runs one Avalon-MM style read or write
// on the traffic-controller CSR bus and posts data/status back into the mailbox.
module hssi_tc_mailbox_bridge #(
  parameter int TC_ADDR_W      = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_wr,
  input  logic                 host_rd,
  input  logic [3:0]           host_addr,
  input  logic [DATA_W-1:0]    host_wrdata,
  output logic [DATA_W-1:0]    host_rddata,
  output logic                 host_rdvalid,
  output logic [TC_ADDR_W-1:0] tc_address,
  output logic                 tc_read,
  output logic                 tc_write,
  output logic [DATA_W-1:0]    tc_writedata,
  input  logic [DATA_W-1:0]    tc_readdata,
  input  logic                 tc_readdatavalid,
  input  logic                 tc_waitrequest,
  output logic                 busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CMD_NOOP = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;
  localparam logic [1:0] CMD_BAD  = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  state_t state, state_nxt;

  logic [1:0]        cmd_q;
  logic              ack, tmo, cmd_err;
  logic [DATA_W-1:0] addr_q, wrdata_q, rddata_q;
  logic [CNT_W-1:0]  tmo_cnt;

  logic [1:0]        new_cmd;
  logic              cmd_wr, start, accept, rd_done, wr_done, done, expire;
  logic [DATA_W-1:0] rd_mux;

  assign new_cmd = host_wrdata[1:0];
  assign cmd_wr  = host_wr && (host_addr == 4'h0);
  assign start   = cmd_wr && (state == IDLE) && ((new_cmd == CMD_RD) || (new_cmd == CMD_WR));
  assign accept  = (state == ISSUE) && (tc_read || tc_write) && !tc_waitrequest;
  // A read whose data arrives in its own accept cycle completes without visiting WAIT_RD.
  assign rd_done = (accept && tc_read && tc_readdatavalid) ||
                   ((state == WAIT_RD) && tc_readdatavalid);
  assign wr_done = accept && tc_write;
  assign done    = rd_done || wr_done;
  assign expire  = (state != IDLE) && (tmo_cnt == LAST) && !done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE: begin
        if (done || expire) state_nxt = IDLE;
        else if (accept)    state_nxt = WAIT_RD;
      end
      WAIT_RD: if (done || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (host_addr)
      4'h0:    rd_mux = DATA_W'({cmd_err, busy, tmo, ack, cmd_q});
      4'h4:    rd_mux = addr_q;
      4'h8:    rd_mux = rddata_q;
      4'hC:    rd_mux = wrdata_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q        <= '0;
      ack          <= 1'b0;
      tmo          <= 1'b0;
      cmd_err      <= 1'b0;
      addr_q       <= '0;
      wrdata_q     <= '0;
      rddata_q     <= '0;
      tmo_cnt      <= '0;
      host_rddata  <= '0;
      host_rdvalid <= 1'b0;
      tc_address   <= '0;
      tc_read      <= 1'b0;
      tc_write     <= 1'b0;
      tc_writedata <= '0;
      busy         <= 1'b0;
    end else begin
      host_rdvalid <= host_rd;
      if (host_rd) host_rddata <= rd_mux;

      if (host_wr && (state == IDLE)) begin
        if (host_addr == 4'h4) addr_q   <= host_wrdata;
        if (host_addr == 4'hC) wrdata_q <= host_wrdata;
      end

      if (cmd_wr) begin
        if (state != IDLE) cmd_err <= 1'b1;
        else begin
          cmd_q <= new_cmd;
          case (new_cmd)
            CMD_NOOP: begin ack <= 1'b0; tmo <= 1'b0; cmd_err <= 1'b0; end
            CMD_BAD:  cmd_err <= 1'b1;
            default:  begin ack <= 1'b0; tmo <= 1'b0; end
          endcase
        end
      end

      if (start) begin
        tc_read      <= (new_cmd == CMD_RD);
        tc_write     <= (new_cmd == CMD_WR);
        tc_address   <= TC_ADDR_W'(addr_q);
        tc_writedata <= wrdata_q;
        tmo_cnt      <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (accept) begin
        tc_read  <= 1'b0;
        tc_write <= 1'b0;
      end
      if (done)    ack      <= 1'b1;
      if (rd_done) rddata_q <= tc_readdata;

      if (expire) begin
        tc_read  <= 1'b0;
        tc_write <= 1'b0;
        ack      <= 1'b1;
        tmo      <= 1'b1;
        if (cmd_q == CMD_RD) rddata_q <= '1;
      end

      busy <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_hssi_tc_mailbox_bridge.sv
// Directed bench: a register-level vector table plus hand sequences for bus transactions.
module tb_hssi_tc_mailbox_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_wr = 1'b0, host_rd = 1'b0;
  logic [3:0]  host_addr = '0;
  logic [31:0] host_wrdata = '0;
  logic [31:0] host_rddata;
  logic        host_rdvalid;
  logic [15:0] tc_address;
  logic        tc_read, tc_write;
  logic [31:0] tc_writedata;
  logic [31:0] tc_readdata = '0;
  logic        tc_readdatavalid = 1'b0;
  logic        tc_waitrequest = 1'b0;
  logic        busy;

  hssi_tc_mailbox_bridge #(.TC_ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst),
    .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr), .host_wrdata(host_wrdata),
    .host_rddata(host_rddata), .host_rdvalid(host_rdvalid),
    .tc_address(tc_address), .tc_read(tc_read), .tc_write(tc_write), .tc_writedata(tc_writedata),
    .tc_readdata(tc_readdata), .tc_readdatavalid(tc_readdatavalid),
    .tc_waitrequest(tc_waitrequest), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int rd_cycles = 0, wr_cycles = 0, req_starts = 0, unstable = 0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  // Bus monitor: request-cycle counts, request starts, and addr/data stability while requesting.
  always @(negedge clk) begin
    if (tc_read)  rd_cycles++;
    if (tc_write) wr_cycles++;
    if ((tc_read || tc_write) && !prev_req) req_starts++;
    if ((tc_read || tc_write) && prev_req &&
        ((tc_address != prev_addr) || (tc_writedata != prev_data))) unstable++;
    prev_req  = tc_read || tc_write;
    prev_addr = tc_address;
    prev_data = tc_writedata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    host_addr = a; host_wrdata = d; host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic host_read(input string name, input logic [3:0] a, input logic [31:0] exp);
    host_addr = a; host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    chk({name, "_vld"}, 32'(host_rdvalid), 32'd1);
    chk(name, host_rddata, exp);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin tick(); n++; end
    chk(name, 32'(busy), 32'd0);
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int base_rd, base_wr, base_st;

    vecs[0]  = '{0, 1, 4'h0, 32'h0,         32'h0};
    vecs[1]  = '{0, 1, 4'h4, 32'h0,         32'h0};
    vecs[2]  = '{0, 1, 4'h8, 32'h0,         32'h0};
    vecs[3]  = '{1, 0, 4'h4, 32'h1234_5678, 32'h0};
    vecs[4]  = '{0, 1, 4'h4, 32'h0,         32'h1234_5678};
    vecs[5]  = '{1, 0, 4'hC, 32'hDEAD_BEEF, 32'h0};
    vecs[6]  = '{1, 1, 4'hC, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[7]  = '{0, 1, 4'hC, 32'h0,         32'hCAFE_F00D};
    vecs[8]  = '{1, 0, 4'h8, 32'h55,        32'h0};
    vecs[9]  = '{0, 1, 4'h8, 32'h0,         32'h0};
    vecs[10] = '{1, 0, 4'h2, 32'h77,        32'h0};
    vecs[11] = '{0, 1, 4'h2, 32'h0,         32'h0};
    vecs[12] = '{0, 1, 4'hF, 32'h0,         32'h0};
    vecs[13] = '{1, 0, 4'h0, 32'h3,         32'h0};
    vecs[14] = '{0, 1, 4'h0, 32'h0,         32'h23};
    vecs[15] = '{1, 0, 4'h0, 32'h0,         32'h0};
    vecs[16] = '{0, 1, 4'h0, 32'h0,         32'h0};

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_tc_read",  32'(tc_read),      32'd0);
    chk("rst_tc_write", 32'(tc_write),     32'd0);
    chk("rst_tc_addr",  32'(tc_address),   32'd0);
    chk("rst_tc_wdata", tc_writedata,      32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_rdvalid",  32'(host_rdvalid), 32'd0);
    chk("rst_rddata",   host_rddata,       32'd0);

    // Register-level vectors; none of these may start a bus transaction.
    for (int i = 0; i < 17; i++) begin
      host_wr = vecs[i].wr; host_rd = vecs[i].rd;
      host_addr = vecs[i].addr; host_wrdata = vecs[i].wdata;
      tick();
      host_wr = 1'b0; host_rd = 1'b0;
      chk($sformatf("vec%0d_rdvalid", i), 32'(host_rdvalid), 32'(vecs[i].rd));
      if (vecs[i].rd) chk($sformatf("vec%0d_rddata", i), host_rddata, vecs[i].exp);
      chk($sformatf("vec%0d_tc_idle", i), {30'd0, tc_read, tc_write}, 32'd0);
    end
    tick();
    chk("rdvalid_one_cycle", 32'(host_rdvalid), 32'd0);

    // Read to 0x100, data returned a few cycles after accept; CMD read in the completion cycle.
    base_rd = rd_cycles; base_st = req_starts;
    tc_waitrequest = 1'b0;
    host_write(4'h4, 32'h100);
    host_write(4'h0, 32'h1);
    chk("rd_rise",  32'(tc_read),    32'd1);
    chk("rd_addr",  32'(tc_address), 32'h100);
    chk("rd_busy",  32'(busy),       32'd1);
    tick();
    chk("rd_accepted", 32'(tc_read), 32'd0);
    chk("rd_wait_busy", 32'(busy),   32'd1);
    tick(); tick();
    tc_readdata = 32'h40; tc_readdatavalid = 1'b1;
    host_addr = 4'h0; host_rd = 1'b1;
    tick();
    tc_readdatavalid = 1'b0; tc_readdata = '0; host_rd = 1'b0;
    chk("rd_cmd_in_completion", host_rddata, 32'h11);
    wait_idle("rd_idle", 20);
    chk("rd_pulse_cycles", 32'(rd_cycles - base_rd), 32'd1);
    chk("rd_starts", 32'(req_starts - base_st), 32'd1);
    host_read("rd_cmd", 4'h0, 32'h5);
    host_read("rd_data", 4'h8, 32'h40);

    // Write to 0x200 stalled by waitrequest for 5 cycles.
    base_wr = wr_cycles; unstable = unstable;
    tc_waitrequest = 1'b1;
    host_write(4'h4, 32'h200);
    host_write(4'hC, 32'h1);
    host_write(4'h0, 32'h2);
    chk("wr_rise", 32'(tc_write), 32'd1);
    chk("wr_addr", 32'(tc_address), 32'h200);
    chk("wr_data", tc_writedata, 32'h1);
    repeat (5) tick();
    chk("wr_held", 32'(tc_write), 32'd1);
    tc_waitrequest = 1'b0;
    tick();
    chk("wr_drop", 32'(tc_write), 32'd0);
    chk("wr_busy_low", 32'(busy), 32'd0);
    chk("wr_cycles", 32'(wr_cycles - base_wr), 32'd6);
    chk("wr_stable", 32'(unstable), 32'd0);
    host_read("wr_cmd", 4'h0, 32'h6);

    // Commands and ADDRESS writes while busy are rejected.
    base_st = req_starts;
    tc_waitrequest = 1'b1;
    host_write(4'h4, 32'h40);
    host_write(4'h0, 32'h2);
    host_write(4'h0, 32'h1);
    host_write(4'h4, 32'h99);
    chk("busy_addr_kept", 32'(tc_address), 32'h40);
    chk("busy_no_read", 32'(tc_read), 32'd0);
    host_read("busy_cmd", 4'h0, 32'h32);
    tc_waitrequest = 1'b0;
    tick();
    wait_idle("busy_idle", 20);
    tick(); tick();
    chk("busy_one_txn", 32'(req_starts - base_st), 32'd1);
    host_read("busy_addr_rb", 4'h4, 32'h40);
    host_read("busy_cmd_done", 4'h0, 32'h26);
    host_write(4'h0, 32'h0);
    host_read("noop_cmd", 4'h0, 32'h0);

    // Read to a slave that never accepts: abort after TIMEOUT_CYCLES.
    base_rd = rd_cycles;
    tc_waitrequest = 1'b1;
    host_write(4'h4, 32'h0D);
    host_write(4'h0, 32'h1);
    for (int n = 0; n < 1100 && tc_read; n++) tick();
    chk("tmo_drop", 32'(tc_read), 32'd0);
    chk("tmo_cycles", 32'(rd_cycles - base_rd), 32'd1024);
    chk("tmo_busy", 32'(busy), 32'd0);
    host_read("tmo_cmd", 4'h0, 32'hD);
    host_read("tmo_rddata", 4'h8, 32'hFFFF_FFFF);

    // Write accepted in the very cycle the timeout would fire: completion wins.
    base_wr = wr_cycles;
    host_write(4'hC, 32'hA5A5_0001);
    host_write(4'h0, 32'h2);
    repeat (1023) tick();
    tc_waitrequest = 1'b0;
    tick();
    chk("race_drop", 32'(tc_write), 32'd0);
    chk("race_cycles", 32'(wr_cycles - base_wr), 32'd1024);
    host_read("race_cmd", 4'h0, 32'h6);

    // Reset while a read is stalled, followed by a stray readdatavalid.
    tc_waitrequest = 1'b1;
    host_write(4'h4, 32'h100);
    host_write(4'h0, 32'h1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_read", 32'(tc_read), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_addr", 32'(tc_address), 32'd0);
    chk("rstmid_rdvalid", 32'(host_rdvalid), 32'd0);
    tc_readdata = 32'h1234; tc_readdatavalid = 1'b1;
    tick();
    tc_readdatavalid = 1'b0; tc_readdata = '0;
    tick();
    chk("rstmid_idle", 32'(busy), 32'd0);
    host_read("rstmid_cmd", 4'h0, 32'h0);
    host_read("rstmid_rddata", 4'h8, 32'h0);
    host_read("rstmid_addr_rb", 4'h4, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hssi_tc_mailbox_bridge.md
Name: hssi_tc_mailbox_bridge

Overview:
- Mailbox-to-traffic-controller bridge behind the HSSI KPI AFU CSR window at 0x40030.
- Host software writes the command, address and write-data mailbox registers. The block runs one Avalon-MM style read or write on the traffic generator/monitor CSR bus, then posts read data and completion status back into the mailbox.
- Downstream it drives the TG (0x00-0xF5), TM (0x100-0x10C) and loopback (0x200) register space.

Parameters:
- TC_ADDR_W, 16, width of tc_address; mailbox address bits above this width are ignored.
- DATA_W, 32, mailbox and traffic-controller data width.
- TIMEOUT_CYCLES, 1024, cycles allowed from request issue to completion before abort.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- host_wr  in  1  mailbox register write strobe, one cycle.
- host_rd  in  1  mailbox register read strobe, one cycle.
- host_addr  in  4  byte offset: 0x0 CMD/STATUS, 0x4 ADDRESS, 0x8 RDDATA (read-only), 0xC WRDATA.
- host_wrdata  in  DATA_W  write data.
- host_rddata  out  DATA_W  read data, valid with host_rdvalid.
- host_rdvalid  out  1  pulses exactly 1 cycle after host_rd.
- tc_address  out  TC_ADDR_W  traffic-controller register address.
- tc_read  out  1  read request; held until accepted.
- tc_write  out  1  write request; held until accepted.
- tc_writedata  out  DATA_W  write data.
- tc_readdata  in  DATA_W  read data.
- tc_readdatavalid  in  1  read data valid.
- tc_waitrequest  in  1  slave stall; a request is accepted in any cycle where request is high and tc_waitrequest is low.
- busy  out  1  high while a transaction is outstanding.

Behaviour:
- Reset values, applied at the clock edge with rst high:
  - all mailbox registers, host_rddata, host_rdvalid, tc_read, tc_write, tc_address, tc_writedata, busy = 0;
  - FSM = IDLE.
- CMD/STATUS read layout:
  - [1:0] last command;
  - [2] ACK, completion;
  - [3] TIMEOUT;
  - [4] busy;
  - [5] CMD_ERR;
  - others 0.
- Writes to CMD:
  - cmd 1 = RD, 2 = WR, 0 = NOOP, 3 = illegal.
  - IDLE plus RD/WR: clear ACK and TIMEOUT, latch cmd, move to ISSUE next cycle. tc_read/tc_write rises 1 cycle after the host write.
  - IDLE plus NOOP: clear ACK, TIMEOUT and CMD_ERR.
  - Illegal cmd 3: set CMD_ERR; no transaction.
  - Any CMD write while busy: ignored, sets CMD_ERR.
- ADDRESS and WRDATA writes while busy are ignored. tc_address and tc_writedata are sampled from the mailbox on entry to ISSUE and stay stable until completion.
- FSM states IDLE, ISSUE, WAIT_RD:
  - ISSUE, WR: hold tc_write until accepted. On the accept cycle, ACK=1 next cycle and return to IDLE.
  - ISSUE, RD: hold tc_read until accepted, then go to WAIT_RD. If tc_readdatavalid is high in the accept cycle, capture the data and complete directly.
  - WAIT_RD: on tc_readdatavalid, RDDATA <= tc_readdata, ACK=1, go to IDLE.
  - tc_readdatavalid outside WAIT_RD or the RD accept cycle is ignored.
- Timeout:
  - Counter clears on ISSUE entry and increments every cycle in ISSUE/WAIT_RD.
  - When it reaches TIMEOUT_CYCLES-1, the request drops next cycle, TIMEOUT=1 and ACK=1.
  - For RD, RDDATA = all ones. Return to IDLE.
  - If a real completion and the timeout fall in the same cycle, the completion wins and TIMEOUT stays 0.
- busy = (state != IDLE). ACK and busy are never both 1.
- Host reads return the register value 1 cycle later. A read of CMD in the completion cycle returns pre-completion state.
- Host host_wr and host_rd in the same cycle: both are honoured; the read returns the old value.
- Unmapped offsets read 0; writes to them are ignored.
- Reset mid-transaction: tc_read/tc_write are low the cycle after the rst edge, and the outstanding transaction is abandoned. A late tc_readdatavalid is ignored.

Test Plan:
- Write ADDRESS=0x100, CMD=RD; slave waitrequest=0, readdatavalid 3 cycles later with 0x0000_0040 -> one tc_read pulse at addr 0x100; CMD reads 0x5; RDDATA=0x40.
- Write ADDRESS=0x200, WRDATA=0x1, CMD=WR; waitrequest held 5 cycles -> tc_write high exactly 6 cycles with stable addr/data; busy low and ACK=1 afterwards; CMD reads 0x6.
- RD to 0x0D, slave never responds -> request dropped after 1024 cycles; CMD reads 0xD; RDDATA=0xFFFF_FFFF.
- CMD=RD written while busy, then ADDRESS rewritten -> no second transaction; tc_address unchanged; CMD_ERR=1; later NOOP write clears it and CMD[5:2]=0.
- Write CMD=3 -> no tc activity; CMD reads 0x23.
- Assert rst while tc_read is stalled; send a late readdatavalid -> all outputs 0 after the edge; CMD reads 0 and RDDATA stays 0.
